// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle processor control FSM:
// state enum, opcode and ALUOp codes, and the datapath select encodings.
package mc_ctrl_pkg;

  localparam int OPC_W   = 4;
  localparam int FUNCT_W = 4;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_LW    = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SW    = 4'h3;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_BNE   = 4'h5;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'h6;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [1:0] SRC_A_PC  = 2'd0;
  localparam logic [1:0] SRC_A_ONE = 2'd1;
  localparam logic [1:0] SRC_A_REG = 2'd2;
  localparam logic [1:0] SRC_A_IMM = 2'd3;

  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_ONE = 2'd1;
  localparam logic [1:0] SRC_B_IMM = 2'd2;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] instr);
    return instr[15 -: OPC_W];
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the control FSM (master) and the ALU datapath (slave).
interface multicycle_control_fsm_if;

  logic [15:0] input_instr;
  logic        input_zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        pc_src;
  logic        halted;

  modport master (
    input  input_instr, input_zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted
  );

  modport slave (
    output input_instr, input_zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted
  );

endinterface

// File: rtl/multicycle_control_fsm_perf.sv
// Free-running performance counters (cycles, retired instructions) used when
// MC_CTRL_PERF_CNT_EN is defined; both wrap at 16 bits and clear on reset.
module mc_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_en,
  input  logic        retire_en,
  output logic [15:0] retired_cnt,
  output logic [15:0] cycle_cnt
);

  logic [1:0]  cnt_en;
  logic [15:0] cnt_reg [2];

  assign cnt_en = {retire_en, cycle_en};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= 16'd0;
        end else if (cnt_en[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign cycle_cnt   = cnt_reg[0];
  assign retired_cnt = cnt_reg[1];

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 16-bit multi-cycle processor. Define
// MC_CTRL_PERF_CNT_EN to add the retired_cnt/cycle_cnt counter ports.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]               retired_cnt,
  output logic [15:0]               cycle_cnt
`endif
);

  state_t             state_reg;
  state_t             state_next;
  logic [OPC_W-1:0]   opcode;
  logic [FUNCT_W-1:0] funct;
  logic               unused_instr_bits;

  assign opcode            = opcode_of(bus.input_instr);
  assign funct             = bus.input_instr[FUNCT_W-1:0];
  assign unused_instr_bits = ^bus.input_instr[11:FUNCT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_RTYPE:       state_next = S_EXEC_R;
          OPC_ADDI:        state_next = S_EXEC_I;
          OPC_LW, OPC_SW:  state_next = S_MEM_ADDR;
          OPC_BEQ, OPC_BNE: state_next = S_BRANCH;
          OPC_JMP:         state_next = S_JUMP;
          default:         state_next = S_HALT;
        endcase
      end
      S_EXEC_R:   state_next = S_ALU_WB;
      S_EXEC_I:   state_next = S_ALU_WB;
      S_ALU_WB:   state_next = S_FETCH;
      S_MEM_ADDR: state_next = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is asserted, even mid-stall.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_REG;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PC_SRC_ALU;
    bus.halted     = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRC_B_ONE;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = SRC_B_IMM;
        S_EXEC_R: begin
          bus.alu_src_a = SRC_A_REG;
          bus.alu_op    = 4'(funct);
        end
        S_EXEC_I, S_MEM_ADDR: begin
          bus.alu_src_a = SRC_A_REG;
          bus.alu_src_b = SRC_B_IMM;
        end
        S_ALU_WB: bus.reg_write = 1'b1;
        S_MEM_RD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = SRC_A_REG;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = PC_SRC_ALUOUT;
          bus.pc_write  = (opcode == OPC_BEQ) ? bus.input_zero : !bus.input_zero;
        end
        // Jump target was computed into ALUOut during DECODE.
        S_JUMP: begin
          bus.alu_src_b = SRC_B_IMM;
          bus.pc_src    = PC_SRC_ALUOUT;
          bus.pc_write  = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  mc_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .cycle_en    (state_reg != S_HALT),
    .retire_en   ((state_reg != S_FETCH) && (state_next == S_FETCH)),
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm; the counter check runs only
// when MC_CTRL_PERF_CNT_EN is defined.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

`ifdef MC_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] cycle_cnt;
`endif

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        mr;
    logic        zr;
    logic [15:0] instr;
    logic [16:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];

  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
  //  alu_src_a, alu_src_b, alu_op, pc_src, halted}
  function automatic logic [16:0] ctl(
    input logic pcw, irw, iord, mrd, mwr, rw, m2r,
    input logic [1:0] sa, sbb, input logic [3:0] op, input logic pcs, hlt);
    return {pcw, irw, iord, mrd, mwr, rw, m2r, sa, sbb, op, pcs, hlt};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
            bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rst, mr, zr, input logic [15:0] instr,
                      input logic [16:0] exp, input string tag);
    item_t it;
    it.rst = rst; it.mr = mr; it.zr = zr; it.instr = instr; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic push_reset(input string tag);
    push(1'b1, 1'b1, 1'b0, 16'h0000, 17'd0, tag);
  endtask

  // Expected per-cycle control vectors for one instruction, derived from the opcode table.
  task automatic queue_instr(input logic [15:0] instr, input logic zero,
                             input int fetch_stalls, input int mem_stalls);
    logic [3:0] opc;
    logic [3:0] fn;
    opc = instr[15:12];
    fn  = instr[3:0];
    for (int i = 0; i < fetch_stalls; i++)
      push(0, 0, zero, instr, ctl(0,0,0,1,0,0,0, 2'd0,2'd1, 4'd0, 0,0), "fetch_stall");
    push(0, 1, zero, instr, ctl(1,1,0,1,0,0,0, 2'd0,2'd1, 4'd0, 0,0), "fetch");
    push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd0,2'd2, 4'd0, 0,0), "decode");
    case (opc)
      4'h0: begin
        push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd2,2'd0, fn, 0,0), "exec_r");
        push(0, 1, zero, instr, ctl(0,0,0,0,0,1,0, 2'd0,2'd0, 4'd0, 0,0), "alu_wb");
      end
      4'h1: begin
        push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd2,2'd2, 4'd0, 0,0), "exec_i");
        push(0, 1, zero, instr, ctl(0,0,0,0,0,1,0, 2'd0,2'd0, 4'd0, 0,0), "alu_wb");
      end
      4'h2: begin
        push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd2,2'd2, 4'd0, 0,0), "mem_addr");
        for (int i = 0; i < mem_stalls; i++)
          push(0, 0, zero, instr, ctl(0,0,1,1,0,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_rd_stall");
        push(0, 1, zero, instr, ctl(0,0,1,1,0,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_rd");
        push(0, 1, zero, instr, ctl(0,0,0,0,0,1,1, 2'd0,2'd0, 4'd0, 0,0), "mem_wb");
      end
      4'h3: begin
        push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd2,2'd2, 4'd0, 0,0), "mem_addr");
        for (int i = 0; i < mem_stalls; i++)
          push(0, 0, zero, instr, ctl(0,0,1,0,1,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_wr_stall");
        push(0, 1, zero, instr, ctl(0,0,1,0,1,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_wr");
      end
      4'h4, 4'h5: begin
        logic take;
        take = (opc == 4'h4) ? zero : !zero;
        push(0, 1, zero, instr, ctl(take,0,0,0,0,0,0, 2'd2,2'd0, 4'd1, 1,0), "branch");
      end
      4'h6: push(0, 1, zero, instr, ctl(1,0,0,0,0,0,0, 2'd0,2'd2, 4'd0, 1,0), "jump");
      default:
        for (int i = 0; i < 5; i++)
          push(0, 1, zero, instr, ctl(0,0,0,0,0,0,0, 2'd0,2'd0, 4'd0, 0,1), "halt");
    endcase
  endtask

  // Pops one expected cycle at a time: drive after the edge, compare at negedge.
  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      reset           = it.rst;
      bus.mem_ready   = it.mr;
      bus.input_zero  = it.zr;
      bus.input_instr = it.instr;
      @(negedge clk);
      $display("tb: %-13s instr=%h rst=%0b mr=%0b zero=%0b ctl=%h", it.tag, it.instr,
               it.rst, it.mr, it.zr, obs_vec());
      check(it.tag, 32'(obs_vec()), 32'(it.exp));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.mem_ready   = 1'b1;
    bus.input_zero  = 1'b0;
    bus.input_instr = 16'h0000;
    @(posedge clk);
    #1;

    push_reset("reset0");
    push_reset("reset1");
    queue_instr(16'h0123, 1'b0, 0, 0);   // RTYPE funct 3
    queue_instr(16'h1234, 1'b0, 1, 0);   // ADDI, one fetch stall
    queue_instr(16'h2abc, 1'b0, 0, 3);   // LW with three wait cycles
    queue_instr(16'h3456, 1'b1, 0, 2);   // SW with two wait cycles
    queue_instr(16'h4000, 1'b1, 0, 0);   // BEQ taken
    queue_instr(16'h4000, 1'b0, 0, 0);   // BEQ not taken
    queue_instr(16'h5000, 1'b1, 0, 0);   // BNE not taken
    queue_instr(16'h5000, 1'b0, 0, 0);   // BNE taken
    queue_instr(16'h6000, 1'b0, 0, 0);   // JMP
    queue_instr(16'h0457, 1'b0, 0, 0);   // RTYPE SLT
    queue_instr(16'h9000, 1'b0, 0, 0);   // illegal opcode halts
    push_reset("reset_halt");
    // SW interrupted by reset during its memory stall
    push(0, 1, 0, 16'h3000, ctl(1,1,0,1,0,0,0, 2'd0,2'd1, 4'd0, 0,0), "fetch");
    push(0, 1, 0, 16'h3000, ctl(0,0,0,0,0,0,0, 2'd0,2'd2, 4'd0, 0,0), "decode");
    push(0, 1, 0, 16'h3000, ctl(0,0,0,0,0,0,0, 2'd2,2'd2, 4'd0, 0,0), "mem_addr");
    push(0, 0, 0, 16'h3000, ctl(0,0,1,0,1,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_wr_stall");
    push(0, 0, 0, 16'h3000, ctl(0,0,1,0,1,0,0, 2'd0,2'd0, 4'd0, 0,0), "mem_wr_stall");
    push(1, 0, 0, 16'h3000, 17'd0, "reset_mid_wr");
    queue_instr(16'hF000, 1'b0, 0, 0);   // HALT reached from FETCH after reset
    push_reset("reset_end");
    drain();

`ifdef MC_CTRL_PERF_CNT_EN
    queue_instr(16'h1111, 1'b0, 0, 0);
    queue_instr(16'h3222, 1'b0, 0, 0);
    queue_instr(16'h4000, 1'b1, 0, 0);
    drain();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("retired_cnt", 32'(retired_cnt), 32'd3);
    check("cycle_cnt", 32'(cycle_cnt), 32'd11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
